heap_op_scheduler: RTL and testbench



---
 rtl/heap_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/heap_op_scheduler.sv | 146 ++++++++++++++
 tb/tb_heap_op_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_sched_pkg.sv
// Shared opcodes, FSM encoding and size defaults for heap_op_scheduler.
package heap_sched_pkg;
  localparam logic OP_INSERT = 1'b1;
  localparam logic OP_POP    = 1'b0;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] j;

  // Scan from farthest to nearest so the closest requester overwrites.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/heap_op_scheduler.sv
// Shares one heap engine between NREQ requesters, one op in flight at a time.
// Define HEAP_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog.
module heap_op_scheduler
  import heap_sched_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NREQ        = 4,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CNT_W       = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  hp_valid,
  output logic                  hp_opcode,
  output logic [WIDTH-1:0]      hp_data,
  input  logic                  hp_done,
  input  logic [WIDTH-1:0]      hp_root,
  output logic [CNT_W-1:0]      heap_count,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  timeout_flag
);
  localparam int IDX_W = $clog2(NREQ);

  state_t           state;
  logic [IDX_W-1:0] ptr, gnt_idx, arb_idx;
  logic [NREQ-1:0]  arb_gnt, gnt_oh;
  logic             op_q, rej_q, done_seen;
  logic             acc_op, acc_rej, to_hit;
  logic [WIDTH-1:0] data_q, result_q;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  assign req_ready = (state == ST_IDLE && !rst) ? arb_gnt : '0;
  assign acc_op    = req_op[arb_idx];
  // Count is stable between ops, so the reject decision can be made at accept.
  assign acc_rej   = (acc_op == OP_INSERT) ? full : empty;
  assign gnt_oh    = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
  assign hp_opcode = op_q;
  assign hp_data   = data_q;
  assign full      = (heap_count == CNT_W'(DEPTH));
  assign empty     = (heap_count == '0);
  assign busy      = (state != ST_IDLE);

`ifdef HEAP_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            to_flag_q;

  assign to_hit       = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign timeout_flag = to_flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT && !done_seen) ? wait_cnt + 1'b1 : '0;
      if (state == ST_WAIT && !done_seen && !hp_done && to_hit)
        to_flag_q <= 1'b1;
    end
  end
`else
  // Watchdog absent: WAIT never gives up.
  assign to_hit       = (TIMEOUT_CYC < 0);
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      op_q       <= OP_POP;
      data_q     <= '0;
      result_q   <= '0;
      rej_q      <= 1'b0;
      done_seen  <= 1'b0;
      heap_count <= '0;
      hp_valid   <= 1'b0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      hp_valid  <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: if (|req_valid) begin
          gnt_idx  <= arb_idx;
          op_q     <= acc_op;
          data_q   <= req_data[arb_idx*WIDTH +: WIDTH];
          rej_q    <= acc_rej;
          hp_valid <= !acc_rej;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (rej_q) begin
            rsp_valid <= gnt_oh;
            rsp_err   <= 1'b1;
            state     <= ST_RESP;
          end else begin
            result_q  <= hp_root;
            done_seen <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Insert result is the root one cycle after done, once the engine settles.
          if (done_seen) begin
            rsp_valid <= gnt_oh;
            rsp_data  <= (op_q == OP_INSERT) ? hp_root : result_q;
            state     <= ST_RESP;
          end else if (hp_done) begin
            done_seen  <= 1'b1;
            heap_count <= (op_q == OP_INSERT) ? heap_count + 1'b1 : heap_count - 1'b1;
          end else if (to_hit) begin
            rsp_valid <= gnt_oh;
            rsp_err   <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          ptr   <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_heap_op_scheduler.sv
// Scoreboard bench for heap_op_scheduler with a behavioural min-heap engine.
module tb_heap_op_scheduler;
  import heap_sched_pkg::*;
  localparam int WIDTH = 32, NREQ = 4, DEPTH = 31, CNT_W = 6, TIMEOUT_CYC = 64;
  localparam logic [NREQ-1:0] ONE = 1;

  typedef struct packed { logic op; logic [WIDTH-1:0] data; } req_t;
  typedef struct { int g; logic op; logic [WIDTH-1:0] key; logic [WIDTH-1:0] rdata;
                   logic err; int kind; int acc_cyc; } exp_t;

  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req_valid, req_op, req_ready, rsp_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [WIDTH-1:0] rsp_data, hp_data, hp_root;
  logic rsp_err, hp_valid, hp_opcode, hp_done, full, empty, busy, timeout_flag;
  logic [CNT_W-1:0] heap_count;

  heap_op_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH), .CNT_W(CNT_W),
                      .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .hp_valid(hp_valid), .hp_opcode(hp_opcode), .hp_data(hp_data), .hp_done(hp_done),
    .hp_root(hp_root), .heap_count(heap_count), .full(full), .empty(empty), .busy(busy),
    .timeout_flag(timeout_flag));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int min_idx(input logic [WIDTH-1:0] q[$]);
    int m = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] < q[m]) m = i;
    return m;
  endfunction

  function automatic int arb_model(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Engine model: executes an op eng_lat cycles after issue (random if 0).
  logic [WIDTH-1:0] eng_heap[$];
  int eng_cnt = 0, eng_lat = 0, last_done_cyc = -100;
  logic eng_op;
  logic [WIDTH-1:0] eng_data;
  bit withhold = 0, stray = 0;

  initial begin
    hp_done = 0; hp_root = '0;
    forever begin
      @(posedge clk); #1;
      hp_done = 0;
      if (rst) begin
        eng_heap.delete(); eng_cnt = 0; hp_root = '0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0 && !withhold) begin
            if (eng_op) eng_heap.push_back(eng_data);
            else if (eng_heap.size() > 0) eng_heap.delete(min_idx(eng_heap));
            hp_root = (eng_heap.size() > 0) ? eng_heap[min_idx(eng_heap)] : '0;
            hp_done = 1; last_done_cyc = cyc;
          end
        end
        if (hp_valid) begin
          eng_op = hp_opcode; eng_data = hp_data;
          eng_cnt = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 5));
        end
        if (stray) begin hp_done = 1; stray = 0; end
      end
    end
  end

  // Reference model + scoreboard monitor.
  exp_t sb[$];
  logic [WIDTH-1:0] mdl_heap[$];
  int ptr_m = 0, rsp_seen = 0;
  int grant_log[$];
  bit hp_seen = 0, expect_timeout = 0;

  initial forever begin
    exp_t e;
    int g, exp_cyc;
    @(negedge clk);
    if (rst) begin
      sb.delete(); mdl_heap.delete(); ptr_m = 0; hp_seen = 0;
    end else begin
      if (rsp_valid != '0) begin
        rsp_seen++;
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_target", rsp_valid, ONE << e.g);
          chk("rsp_data", rsp_data, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("heap_count", heap_count, mdl_heap.size());
          chk("full", full, mdl_heap.size() == DEPTH);
          chk("empty", empty, mdl_heap.size() == 0);
          exp_cyc = (e.kind == 0) ? last_done_cyc + 2 :
                    (e.kind == 1) ? e.acc_cyc + 2 : e.acc_cyc + 2 + TIMEOUT_CYC;
          chk("rsp_latency", cyc, exp_cyc);
          if (e.kind == 1) chk("no_hp_issue_on_reject", hp_seen, 0);
          ptr_m = (e.g + 1) % NREQ;
        end
      end
      if (hp_valid) begin
        hp_seen = 1;
        if (sb.size() == 0) chk("unexpected_hp_valid", hp_valid, 0);
        else begin
          chk("hp_opcode", hp_opcode, sb[0].op);
          chk("hp_data", hp_data, sb[0].key);
          chk("hp_issue_allowed", sb[0].kind == 1, 0);
        end
      end
      if (req_ready != '0) begin
        g = arb_model(req_valid, ptr_m);
        chk("grant", req_ready, (g < 0) ? '0 : ONE << g);
        if (g >= 0) begin
          grant_log.push_back(g);
          e.g = g; e.op = req_op[g]; e.key = req_data[g*WIDTH +: WIDTH];
          e.acc_cyc = cyc; e.err = 0; e.kind = 0; e.rdata = '0;
          if (expect_timeout) begin
            e.err = 1; e.kind = 2;
          end else if (e.op == OP_INSERT) begin
            if (mdl_heap.size() == DEPTH) begin e.err = 1; e.kind = 1; end
            else begin mdl_heap.push_back(e.key); e.rdata = mdl_heap[min_idx(mdl_heap)]; end
          end else begin
            if (mdl_heap.size() == 0) begin e.err = 1; e.kind = 1; end
            else begin g = min_idx(mdl_heap); e.rdata = mdl_heap[g]; mdl_heap.delete(g); end
          end
          sb.push_back(e);
          hp_seen = 0;
        end
      end
    end
  end

  // Requester driver: each requester replays its own plan queue.
  req_t plan[NREQ][$];

  function automatic bit plans_pending();
    for (int r = 0; r < NREQ; r++) if (plan[r].size() > 0) return 1;
    return 0;
  endfunction

  task automatic step();
    logic [NREQ-1:0] acc;
    req_t t;
    @(negedge clk); acc = req_ready;
    @(posedge clk); #2;
    for (int r = 0; r < NREQ; r++) begin
      if (acc[r]) req_valid[r] = 0;
      if (!req_valid[r] && plan[r].size() > 0) begin
        t = plan[r].pop_front();
        req_valid[r] = 1; req_op[r] = t.op; req_data[r*WIDTH +: WIDTH] = t.data;
      end
    end
  endtask

  task automatic run_batch(input int budget);
    int n = 0;
    do begin step(); n++; end
    while ((plans_pending() || req_valid != '0 || sb.size() > 0 || busy) && n < budget);
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL batch_timeout actual=%0d cycles required=<%0d", n, budget);
    end
  endtask

  task automatic add(input int r, input logic op, input logic [WIDTH-1:0] d);
    req_t t;
    t.op = op; t.data = d;
    plan[r].push_back(t);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n, rsp_before;
    req_valid = '0; req_op = '0; req_data = '0; rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_count", heap_count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_hp_valid", hp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_timeout_flag", timeout_flag, 0);
    @(posedge clk); #2 rst = 0;

    // 1: three inserts from requester 0, engine done 3 cycles after issue
    eng_lat = 3;
    add(0, OP_INSERT, 5); add(0, OP_INSERT, 3); add(0, OP_INSERT, 9);
    run_batch(200);
    @(negedge clk); chk("t1_count", heap_count, 3);
    @(posedge clk); #2;

    // 2: fourth element via req3 (pointer -> 0), then all four pop together
    eng_lat = 0;
    add(3, OP_INSERT, $urandom);
    run_batch(200);
    grant_log.delete();
    for (int r = 0; r < NREQ; r++) add(r, OP_POP, 0);
    run_batch(300);
    chk("t2_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], i);
    @(negedge clk); chk("t2_empty", empty, 1);
    @(posedge clk); #2;

    // 3: pop on an empty heap is rejected without engine traffic
    add(1, OP_POP, 0);
    run_batch(100);

    // 4: fill to capacity from random requesters, then one more insert
    for (int i = 0; i < DEPTH; i++) add($urandom_range(0, NREQ-1), OP_INSERT, $urandom);
    run_batch(2000);
    add(0, OP_INSERT, 7);
    run_batch(100);
    @(negedge clk);
    chk("t4_count", heap_count, DEPTH);
    chk("t4_full", full, 1);
    @(posedge clk); #2;

    // Random mixed traffic, then pop-heavy traffic to drain through empty
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < 12; i++) add(r, logic'($urandom_range(0, 1)), $urandom);
    run_batch(3000);
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < 12; i++) add(r, logic'($urandom_range(0, 3) == 0), $urandom);
    run_batch(3000);

    // 5: reset while waiting on the engine
    eng_lat = 12;
    add(2, OP_INSERT, 42);
    n = 0;
    do begin step(); n++; end while (!hp_seen && n < 20);
    chk("t5_reached_issue", hp_seen, 1);
    step(); step();
    @(negedge clk); chk("t5_busy_in_wait", busy, 1);
    @(posedge clk); #2;
    rsp_before = rsp_seen;
    for (int r = 0; r < NREQ; r++) plan[r].delete();
    req_valid = '0; rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_count_after_rst", heap_count, 0);
    @(posedge clk); #2 stray = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_no_rsp", rsp_seen, rsp_before);
    chk("t5_count_after_stray", heap_count, 0);
    chk("t5_idle_after_stray", busy, 0);
    @(posedge clk); #2;
    eng_lat = 0;

`ifdef HEAP_SCHED_TIMEOUT_EN
    // 6: engine never completes; watchdog answers with an error
    withhold = 1; expect_timeout = 1;
    add(2, OP_INSERT, 7);
    run_batch(200);
    expect_timeout = 0; withhold = 0;
    @(negedge clk);
    chk("t6_timeout_flag", timeout_flag, 1);
    chk("t6_count", heap_count, 0);
    @(posedge clk); #2 stray = 1;
    repeat (3) @(posedge clk); #2;
    add(0, OP_INSERT, 8);
    run_batch(200);
    @(negedge clk);
    chk("t6_flag_sticky", timeout_flag, 1);
    chk("t6_count_after", heap_count, 1);
`else
    @(negedge clk);
    chk("timeout_flag_tied", timeout_flag, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
